// File: rtl/mul_seq_ctrl_pkg.sv
// mul_pkg: shared types and width-derived constants for the sequential
// shift-add multiplier (mul_seq_ctrl).
//   - state_t     : controller FSM states IDLE / RUN / DONE
//   - DEF_WIDTH   : default operand width
//   - prod_width  : product width (2*WIDTH)
//   - cnt_width   : step-counter width ($clog2(WIDTH), at least 1)
// No ports.
package mul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int prod_width(input int w);
    return 2 * w;
  endfunction

  function automatic int cnt_width(input int w);
    return ($clog2(w) < 1) ? 1 : $clog2(w);
  endfunction

  localparam int DEF_PROD_W = prod_width(DEF_WIDTH);
  localparam int DEF_CNT_W  = cnt_width(DEF_WIDTH);

endpackage

// File: rtl/mul_seq_ctrl_if.sv
// mul_seq_ctrl_if: operand and result handshakes of the sequential multiplier.
// Signals:
//   in_valid/in_ready : operand pair (m, q) transfer
//   m, q              : WIDTH-bit multiplicand / multiplier
//   out_valid/out_ready : product transfer
//   p                 : 2*WIDTH-bit product
//   busy              : controller is in RUN or DONE
// Handshake rule (both channels): a transfer happens on a rising clk edge
// where valid and ready are both high; the sender keeps valid and data
// stable until that edge, and ready never depends combinationally on valid.
// Modports: slave = the controller, master = producer/consumer side.
interface mul_seq_ctrl_if #(
  parameter int WIDTH = mul_pkg::DEF_WIDTH
);
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     q;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   p;
  logic                 busy;

  modport slave (
    input  in_valid, m, q, out_ready,
    output in_ready, out_valid, p, busy
  );

  modport master (
    output in_valid, m, q, out_ready,
    input  in_ready, out_valid, p, busy
  );
endinterface

// File: rtl/mul_seq_ctrl_row.sv
// mul_row: combinational WIDTH-bit partial-product row.
// Adds (b_bit ? a : 0) to acc_in with a ripple chain of AND-gated full adders.
// Ports:
//   a      in  WIDTH    multiplicand
//   b_bit  in  1        current multiplier bit (gates every cell)
//   acc_in in  WIDTH    running upper accumulator half
//   sum    out WIDTH+1  unsigned sum including carry out
module mul_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b_bit,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH:0]   sum
);
  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_pp;

  assign w_c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    assign w_pp[i]    = a[i] & b_bit;
    assign sum[i]     = acc_in[i] ^ w_pp[i] ^ w_c[i];
    assign w_c[i + 1] = (acc_in[i] & w_pp[i]) | (w_c[i] & (acc_in[i] ^ w_pp[i]));
  end

  assign sum[WIDTH] = w_c[WIDTH];
endmodule

// File: rtl/mul_seq_ctrl.sv
// mul_seq_ctrl: sequential shift-add multiplier controller.
// Accepts (m, q) when in_valid & in_ready, runs WIDTH add-and-shift steps
// through one shared mul_row, then presents the 2*WIDTH-bit product p with
// out_valid until out_ready takes it.
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   bus          slave modport of mul_seq_ctrl_if (handshakes, m, q, p, busy)
//   o_dbg_state  out  current FSM state
// Optional feature: MUL_SEQ_ZERO_SKIP_EN -- when defined, a zero operand at
// accept jumps straight to DONE with p=0 (latency 1).
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic           clk,
  input  logic           rst,
  mul_seq_ctrl_if.slave  bus,
  output state_t         o_dbg_state
);
  localparam int CNT_W = cnt_width(WIDTH);

  state_t             r_state;
  state_t             w_next;
  // Upper accumulator half A. After each shift its top bit is always 0,
  // so only the low WIDTH bits are stored.
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r_mreg;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_p;

  logic [WIDTH:0]     w_sum;
  logic               w_accept;
  logic               w_last;
  logic               w_zero;

  assign w_accept = bus.in_valid & bus.in_ready;
  assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

`ifdef MUL_SEQ_ZERO_SKIP_EN
  assign w_zero = (bus.m == '0) || (bus.q == '0);
`else
  assign w_zero = 1'b0;
`endif

  mul_row #(.WIDTH(WIDTH)) u_row (
    .a      (r_mreg),
    .b_bit  (r_q[0]),
    .acc_in (r_a),
    .sum    (w_sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept)      w_next = w_zero ? ST_DONE : ST_RUN;
      ST_RUN:  if (w_last)        w_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; in_ready is also held low during reset.
  always_comb begin
    bus.in_ready  = (r_state == ST_IDLE) && !rst;
    bus.out_valid = (r_state == ST_DONE);
    bus.busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
    bus.p         = r_p;
    o_dbg_state   = r_state;
  end

  // Datapath: {A, Q} <= {sum, Q} >> 1 on every RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a    <= '0;
      r_q    <= '0;
      r_mreg <= '0;
      r_cnt  <= '0;
      r_p    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_mreg <= bus.m;
            r_a    <= '0;
            r_q    <= bus.q;
            r_cnt  <= '0;
            if (w_zero) r_p <= '0;
          end
        end
        ST_RUN: begin
          r_a   <= w_sum[WIDTH:1];
          r_q   <= {w_sum[0], r_q[WIDTH-1:1]};
          r_cnt <= r_cnt + CNT_W'(1);
          // Post-shift {A[WIDTH-1:0], Q} equals {sum, Q[WIDTH-1:1]}.
          if (w_last) r_p <= {w_sum, r_q[WIDTH-1:1]};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential shift-add multiplier controller that time-shares one W-bit partial-product row across W cycles, replacing a full W×W combinational array where area matters. It accepts an operand pair (m, q) over a valid/ready handshake and sequences the row through W add-and-shift steps. It returns the 2W-bit product p over a second valid/ready handshake. It sits between an operand producer and a result consumer in the lab datapath.

## Interface
- WIDTH, 4: operand width in bits (≥2); product is 2·WIDTH bits.
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands (high only in IDLE, low while rst high).
- m  input  WIDTH  multiplicand, sampled on in_valid & in_ready.
- q  input  WIDTH  multiplier, sampled on in_valid & in_ready.
- out_valid  output  1  p holds a completed product.
- out_ready  input  1  consumer takes p.
- p  output  2·WIDTH  product, registered.
- busy  output  1  high in RUN or DONE.

## Operation
- Clock is clk. Reset is rst, synchronous and active-high. When rst is sampled high: state→IDLE, p=0, out_valid=0, busy=0, step counter=0, accumulator=0. in_ready is 0 while rst is high and 1 from the first cycle after release.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On accept, latch mreg=m, accumulator {A[WIDTH:0], Q[WIDTH-1:0]} = {0, q}, and cnt=0.
  - Then go to RUN.
- RUN:
  - Each cycle computes sum[WIDTH:0] = A[WIDTH-1:0] + (Q[0] ? mreg : 0), unsigned.
  - It then loads {A, Q} ← {sum, Q} >> 1 and sets cnt+1.
  - When cnt = WIDTH-1 at the edge, the final step executes. At that edge p ← {A[WIDTH-1:0], Q} post-shift, out_valid←1, and state→DONE.
- DONE:
  - p and out_valid hold until out_valid & out_ready. At that point out_valid←0 and state→IDLE.
  - No new accept occurs in the same cycle; the next accept is possible one cycle later.
- in_valid during RUN/DONE is ignored, because in_ready=0. Operand inputs may change freely after accept.
- Arithmetic is unsigned only. The product never overflows 2·WIDTH bits.
- rst asserted mid-RUN or mid-DONE aborts the operation. The pending product is discarded and never presented.

## Timing
- Accept on edge ending cycle T. RUN occupies cycles T+1..T+WIDTH. out_valid=1 first in cycle T+WIDTH+1.
- Latency from accept to result is therefore WIDTH+1 cycles. With out_ready held high, throughput is one product per WIDTH+2 cycles.
- p is stable whenever out_valid=1. p retains its last value after handoff and is only 0 after reset.
- All outputs are registered or decoded from state only. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- MUL_SEQ_ZERO_SKIP_EN defined:
  - At accept, if m==0 or q==0, go directly IDLE→DONE with p←0 and out_valid=1 in cycle T+1 (latency 1).
  - RUN is skipped.
- MUL_SEQ_ZERO_SKIP_EN undefined:
  - Zero operands take the full WIDTH+1-cycle path.
  - The result is identical: p=0.

## Structure
- A shared package mul_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the WIDTH-derived constants: product width 2·WIDTH and counter width $clog2(WIDTH).
- One sub-module, mul_row, is natural.
  - It is a purely combinational WIDTH-bit partial-product adder.
  - Inputs are a, b_bit and acc_in; outputs are sum[WIDTH:0].
  - It is built from AND-gated full-adder cells, ripple carry.
- The controller instantiates exactly one mul_row.

## Test plan
- WIDTH=4, m=15, q=15, out_ready=1 → out_valid rises exactly 5 cycles after accept, p=0xE1 (225); in_ready returns 1 one cycle after handoff.
- m=9, q=6 then m=1, q=1 back-to-back with in_valid held → p=54, then p=1; second accept occurs one cycle after first handoff, never earlier.
- Backpressure: m=7, q=11, out_ready=0 for 10 cycles after out_valid → p=77 and out_valid held steady, in_ready=0 throughout; handoff on out_ready=1.
- rst pulsed in 3rd RUN cycle of m=12, q=13 → next cycle out_valid=0, p=0, busy=0; no product 156 ever presented; following m=3, q=5 yields p=15.
- m=0, q=13: with MUL_SEQ_ZERO_SKIP_EN → out_valid in cycle T+1, p=0; without → out_valid in cycle T+5, p=0.
- Exhaustive sweep of all 256 operand pairs at WIDTH=4 with random out_ready → every p matches m·q, count of accepts equals count of handoffs.
